// File: rtl/rtc_write_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// rtc_pkg : state encodings and index->RTC address map for the write sequencer
// Revision: 1.0
// ============================================================================
package rtc_pkg;

  localparam int N_REGS_DEF = 9;
  localparam int IDX_W      = 4;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_NEXT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // Time/date fields first, then the three timer registers.
  function automatic logic [7:0] addr_map(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd0:    addr_map = 8'h21;
      4'd1:    addr_map = 8'h22;
      4'd2:    addr_map = 8'h23;
      4'd3:    addr_map = 8'h24;
      4'd4:    addr_map = 8'h25;
      4'd5:    addr_map = 8'h26;
      4'd6:    addr_map = 8'h41;
      4'd7:    addr_map = 8'h42;
      4'd8:    addr_map = 8'h43;
      default: addr_map = 8'h00;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_write_sequencer_if.sv
`default_nettype none
// ============================================================================
// rtc_write_sequencer_if : control/bus handshake bundle of the write sequencer
// Revision: 1.0
// ============================================================================
interface rtc_write_sequencer_if;
  import rtc_pkg::*;

  logic             startSEQ;
  logic             abortSEQ;
  logic [7:0]       datoSEQ;
  logic             ackSEQ;
  logic [IDX_W-1:0] idxSEQ;
  logic [7:0]       dirSEQ;
  logic [7:0]       wdatoSEQ;
  logic             reqSEQ;
  logic             busySEQ;
  logic             doneSEQ;
  logic             errSEQ;

  modport master (
    output startSEQ, abortSEQ, datoSEQ, ackSEQ,
    input  idxSEQ, dirSEQ, wdatoSEQ, reqSEQ, busySEQ, doneSEQ, errSEQ
  );

  modport slave (
    input  startSEQ, abortSEQ, datoSEQ, ackSEQ,
    output idxSEQ, dirSEQ, wdatoSEQ, reqSEQ, busySEQ, doneSEQ, errSEQ
  );

endinterface
`default_nettype wire

// File: rtl/rtc_write_sequencer_idx_counter.sv
`default_nettype none
// ============================================================================
// rtc_idx_counter : saturating register-index counter with terminal flag
// Revision: 1.0
// ============================================================================
module rtc_idx_counter
  import rtc_pkg::*;
#(
  parameter int N_REGS = N_REGS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REGS - 1);

  assign last = (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (en && !last) begin
      idx <= idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rtc_write_sequencer.sv
`default_nettype none
// ============================================================================
// rtc_write_sequencer : burst-writes the RTC config registers over the RTC bus
// Revision: 1.0
// ============================================================================
module rtc_write_sequencer
  import rtc_pkg::*;
#(
  parameter int N_REGS     = N_REGS_DEF,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clkSEQ,
  input  logic                  resetSEQ,
  rtc_write_sequencer_if.slave  bus
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [3:0]       gap_cnt;
  logic [7:0]       tmo_cnt;
  logic [IDX_W-1:0] idx;
  logic             idx_last;
  logic             idx_en;
  logic             idx_clr;
  logic             gap_end;
  logic             tmo_hit;
  logic             busy;
  logic             done;
  logic [7:0]       dir;
  logic [7:0]       wdato;
  logic             req;
  logic             err;

  assign gap_end = (gap_cnt == GAP_LAST);
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  rtc_idx_counter #(
    .N_REGS (N_REGS)
  ) u_idx (
    .clk   (clkSEQ),
    .rst_n (resetSEQ),
    .clr   (idx_clr),
    .en    (idx_en),
    .idx   (idx),
    .last  (idx_last)
  );

  always_ff @(posedge clkSEQ or negedge resetSEQ) begin
    if (!resetSEQ) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A write already on the bus is never cut: abort in REQ waits for ack or timeout.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (bus.startSEQ) next_state = S_LOAD;
      S_LOAD: next_state = bus.abortSEQ ? S_IDLE : S_REQ;
      S_REQ: begin
        if (bus.ackSEQ)   next_state = bus.abortSEQ ? S_IDLE : S_GAP;
        else if (tmo_hit) next_state = S_IDLE;
      end
      S_GAP: begin
        if (bus.abortSEQ) next_state = S_IDLE;
        else if (gap_end) next_state = S_NEXT;
      end
      S_NEXT: begin
        if (bus.abortSEQ)  next_state = S_IDLE;
        else if (idx_last) next_state = S_DONE;
        else               next_state = S_LOAD;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    idx_en  = (state == S_NEXT) && !bus.abortSEQ && !idx_last;
    idx_clr = (state == S_IDLE) || (state == S_DONE);
  end

  // Counters restart on every state entry, so a self-loop is the only way they advance.
  always_ff @(posedge clkSEQ or negedge resetSEQ) begin
    if (!resetSEQ) begin
      gap_cnt <= '0;
      tmo_cnt <= '0;
      dir     <= '0;
      wdato   <= '0;
      req     <= 1'b0;
      err     <= 1'b0;
    end else begin
      gap_cnt <= (state == S_GAP && next_state == S_GAP) ? gap_cnt + 4'd1 : 4'd0;
      tmo_cnt <= (state == S_REQ && next_state == S_REQ) ? tmo_cnt + 8'd1 : 8'd0;
      req     <= (next_state == S_REQ);
      if (state == S_LOAD) begin
        dir   <= addr_map(idx);
        wdato <= bus.datoSEQ;
      end
      if (state == S_IDLE && bus.startSEQ) begin
        err <= 1'b0;
      end else if (state == S_REQ && !bus.ackSEQ && tmo_hit) begin
        err <= 1'b1;
      end
    end
  end

  assign bus.idxSEQ   = idx;
  assign bus.dirSEQ   = dir;
  assign bus.wdatoSEQ = wdato;
  assign bus.reqSEQ   = req;
  assign bus.busySEQ  = busy;
  assign bus.doneSEQ  = done;
  assign bus.errSEQ   = err;

endmodule
`default_nettype wire

// File: tb/tb_rtc_write_sequencer.sv
`default_nettype none
// ============================================================================
// tb_rtc_write_sequencer : directed/randomized bench with a transaction model
// Revision: 1.0
// ============================================================================
module tb_rtc_write_sequencer;

  localparam int N_REGS = 9;
  localparam int GAP    = 4;
  localparam int TMO    = 255;

  logic clkSEQ = 1'b0;
  logic resetSEQ;
  always #5 clkSEQ = ~clkSEQ;

  rtc_write_sequencer_if bus ();

  rtc_write_sequencer #(
    .N_REGS     (N_REGS),
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TMO)
  ) dut (
    .clkSEQ   (clkSEQ),
    .resetSEQ (resetSEQ),
    .bus      (bus.slave)
  );

  logic [7:0] exp_addr [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
  logic [7:0] cfg [16];
  int         ack_tab [16];
  int         n_checks = 0;
  int         n_fail   = 0;

  logic [7:0] wr_dir[$];
  logic [7:0] wr_dat[$];
  int         wr_t[$];
  int         len_q[$];
  int         done_cnt = 0;
  int         cycle    = 0;
  int         cyc      = 0;
  logic       prev_req = 1'b0;

  assign bus.datoSEQ = cfg[bus.idxSEQ];

  // Bus-timing responder and transaction monitor, evaluated just after each rising edge.
  always begin
    @(posedge clkSEQ);
    #1;
    if (!resetSEQ) begin
      prev_req   = 1'b0;
      cyc        = 0;
      bus.ackSEQ = 1'b0;
    end else begin
      if (bus.reqSEQ) begin
        if (!prev_req) begin
          wr_dir.push_back(bus.dirSEQ);
          wr_dat.push_back(bus.wdatoSEQ);
          wr_t.push_back(cycle);
          cyc = 0;
        end
        cyc++;
        bus.ackSEQ = (ack_tab[bus.idxSEQ] != 0) && (cyc == ack_tab[bus.idxSEQ]);
      end else begin
        if (prev_req) len_q.push_back(cyc);
        bus.ackSEQ = 1'b0;
      end
      prev_req = bus.reqSEQ;
      if (bus.doneSEQ) done_cnt++;
    end
    cycle++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wr_dir.delete();
    wr_dat.delete();
    wr_t.delete();
    len_q.delete();
    done_cnt = 0;
  endtask

  task automatic new_cfg();
    for (int i = 0; i < 16; i++) cfg[i] = 8'($urandom);
  endtask

  task automatic pulse_start();
    bus.startSEQ = 1'b1;
    @(negedge clkSEQ);
    bus.startSEQ = 1'b0;
  endtask

  // kind: 0 done, 1 idle, 2 req on idx arg, 3 busy on idx arg, 4 at least arg writes
  task automatic wait_for(input int kind, input int arg, input int budget, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clkSEQ);
      case (kind)
        0: seen = bus.doneSEQ;
        1: seen = !bus.busySEQ;
        2: seen = bus.reqSEQ && (int'(bus.idxSEQ) == arg);
        3: seen = bus.busySEQ && (int'(bus.idxSEQ) == arg);
        default: seen = (wr_dir.size() >= arg);
      endcase
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  function automatic int last_len();
    return (len_q.size() == 0) ? -1 : len_q[len_q.size()-1];
  endfunction

  task automatic check_burst(input int n, input string tag);
    check({tag, "_count"}, 32'(wr_dir.size()), 32'(n));
    for (int i = 0; i < n && i < wr_dir.size(); i++) begin
      check($sformatf("%s_dir%0d", tag, i), 32'(wr_dir[i]), 32'(exp_addr[i]));
      check($sformatf("%s_dat%0d", tag, i), 32'(wr_dat[i]), 32'(cfg[i]));
    end
  endtask

  task automatic check_spacing(input int n, input string tag);
    for (int i = 0; i + 1 < n && i + 1 < wr_t.size(); i++)
      check($sformatf("%s_gap%0d", tag, i), 32'(wr_t[i+1] - wr_t[i]), 32'(ack_tab[i] + GAP + 2));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetSEQ     = 1'b0;
    bus.startSEQ = 1'b0;
    bus.abortSEQ = 1'b0;
    for (int i = 0; i < 16; i++) ack_tab[i] = 2;
    new_cfg();
    repeat (3) @(negedge clkSEQ);
    check("rst_idx",   32'(bus.idxSEQ),   32'd0);
    check("rst_dir",   32'(bus.dirSEQ),   32'd0);
    check("rst_wdato", 32'(bus.wdatoSEQ), 32'd0);
    check("rst_req",   32'(bus.reqSEQ),   32'd0);
    check("rst_busy",  32'(bus.busySEQ),  32'd0);
    check("rst_done",  32'(bus.doneSEQ),  32'd0);
    check("rst_err",   32'(bus.errSEQ),   32'd0);
    resetSEQ = 1'b1;
    @(negedge clkSEQ);

    // Full burst, fixed ack latency
    clear_mon();
    new_cfg();
    pulse_start();
    check("t1_busy_start", 32'(bus.busySEQ), 32'd1);
    wait_for(0, 0, 300, "t1_done_seen");
    check("t1_idx_in_done", 32'(bus.idxSEQ), 32'(N_REGS - 1));
    @(negedge clkSEQ);
    check("t1_busy_after", 32'(bus.busySEQ), 32'd0);
    check("t1_done_after", 32'(bus.doneSEQ), 32'd0);
    check("t1_idx_after",  32'(bus.idxSEQ),  32'd0);
    check("t1_done_cnt",   32'(done_cnt),    32'd1);
    check("t1_err",        32'(bus.errSEQ),  32'd0);
    check_burst(N_REGS, "t1");
    check_spacing(N_REGS, "t1");

    // Ack never arrives on idx 3
    clear_mon();
    new_cfg();
    ack_tab[3] = 0;
    pulse_start();
    wait_for(1, 0, 800, "t2_idle_seen");
    check("t2_err",      32'(bus.errSEQ),  32'd1);
    check("t2_req",      32'(bus.reqSEQ),  32'd0);
    check("t2_done_cnt", 32'(done_cnt),    32'd0);
    check("t2_req_len",  32'(last_len()),  32'(TMO));
    check_burst(4, "t2");
    ack_tab[3] = 2;
    clear_mon();
    new_cfg();
    pulse_start();
    check("t2_err_clr",  32'(bus.errSEQ),  32'd0);
    check("t2_idx_rst",  32'(bus.idxSEQ),  32'd0);
    wait_for(0, 0, 300, "t2_done_seen");
    @(negedge clkSEQ);
    check("t2_done_cnt2", 32'(done_cnt), 32'd1);
    check_burst(N_REGS, "t2r");

    // Abort while the idx 5 write is on the bus
    clear_mon();
    new_cfg();
    ack_tab[5] = 3;
    pulse_start();
    wait_for(2, 5, 300, "t3_req5_seen");
    bus.abortSEQ = 1'b1;
    @(negedge clkSEQ);
    check("t3_req_held", 32'(bus.reqSEQ), 32'd1);
    wait_for(1, 0, 50, "t3_idle_seen");
    bus.abortSEQ = 1'b0;
    repeat (3) @(negedge clkSEQ);
    check("t3_done_cnt", 32'(done_cnt),   32'd0);
    check("t3_req_len",  32'(last_len()), 32'd3);
    check("t3_err",      32'(bus.errSEQ), 32'd0);
    check("t3_busy",     32'(bus.busySEQ), 32'd0);
    check_burst(6, "t3");

    // Spurious start mid-burst, random ack latencies
    clear_mon();
    new_cfg();
    for (int i = 0; i < 16; i++) ack_tab[i] = int'($urandom_range(1, 6));
    pulse_start();
    wait_for(3, 2, 300, "t4_idx2_seen");
    pulse_start();
    wait_for(0, 0, 400, "t4_done_seen");
    @(negedge clkSEQ);
    check("t4_done_cnt", 32'(done_cnt),    32'd1);
    check("t4_busy",     32'(bus.busySEQ), 32'd0);
    check_burst(N_REGS, "t4");
    check_spacing(N_REGS, "t4");

    // Asynchronous reset while a request is outstanding
    for (int i = 0; i < 16; i++) ack_tab[i] = 2;
    clear_mon();
    new_cfg();
    pulse_start();
    wait_for(2, 1, 100, "t5_req_seen");
    #2;
    resetSEQ = 1'b0;
    #1;
    check("t5_req_async",  32'(bus.reqSEQ),  32'd0);
    check("t5_busy_async", 32'(bus.busySEQ), 32'd0);
    check("t5_idx_async",  32'(bus.idxSEQ),  32'd0);
    @(negedge clkSEQ);
    resetSEQ = 1'b1;
    repeat (2) @(negedge clkSEQ);
    check("t5_busy_after", 32'(bus.busySEQ), 32'd0);
    check("t5_req_after",  32'(bus.reqSEQ),  32'd0);

    // Ack arrives in the very clock the timeout would fire
    clear_mon();
    new_cfg();
    ack_tab[0] = TMO;
    pulse_start();
    wait_for(4, 2, 400, "t6_second_write");
    check("t6_err",     32'(bus.errSEQ),  32'd0);
    check("t6_req_len", 32'(len_q.size() > 0 ? len_q[0] : -1), 32'(TMO));
    check("t6_busy",    32'(bus.busySEQ), 32'd1);
    wait_for(0, 0, 300, "t6_done_seen");
    @(negedge clkSEQ);
    check("t6_done_cnt", 32'(done_cnt), 32'd1);
    check_burst(N_REGS, "t6");
    check_spacing(2, "t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
